core_memory_arbiter: RTL and testbench
======================================

// Module: core_memory_arbiter
// PURPOSE
// - Shares one memory port among NUM_PORTS core-side request ports (multi-hart builds, or split I/D masters).
// - Each port uses the core memory handshake: enable/command/addresses/data/mask in; ready/valid/read data out.
// - One transaction is in flight at a time. Round-robin grant by default.
// PARAMETERS
// - NUM_PORTS   2   number of requesting ports, 2..8
// - ADDR_WIDTH  32  address width
// - DATA_WIDTH  32  data width; the write mask is bitwise, DATA_WIDTH bits
// PORTS
// - clk                  in   1             clock; all state changes on the rising edge
// - reset                in   1             asynchronous, active-low reset
// - port_enable          in   N             per-port request
// - port_command         in   N             per-port request type: 1=write, 0=read
// - port_read_address    in   N*ADDR_WIDTH  per-port read address, port i at slice [i*ADDR_WIDTH +: ADDR_WIDTH]
// - port_write_address   in   N*ADDR_WIDTH  per-port write address
// - port_write_data      in   N*DATA_WIDTH  per-port write data
// - port_write_mask      in   N*DATA_WIDTH  per-port bitwise write mask
// - port_ready           out  N             request accepted this cycle when enable && ready
// - port_valid           out  N             one-cycle completion pulse (read data or write ack)
// - port_read_data       out  DATA_WIDTH    read data, shared by all ports; meaningful only with port_valid
// - memory_enable        out  1             downstream request
// - memory_command       out  1             downstream request type: 1=write, 0=read
// - read_memory_address  out  ADDR_WIDTH    downstream read address
// - write_memory_address out  ADDR_WIDTH    downstream write address
// - write_memory_data    out  DATA_WIDTH    downstream write data
// - write_memory_mask    out  DATA_WIDTH    downstream write mask
// - memory_ready         in   1             downstream accepts when memory_enable && memory_ready
// - memory_valid         in   1             downstream completion; read_memory_data is valid in the same cycle
// - read_memory_data     in   DATA_WIDTH    downstream read data
// BEHAVIOUR
// - States: IDLE, ISSUE, WAIT, RESPOND. Reset value: IDLE.
//   - Reset values: last_grant = NUM_PORTS-1, so port 0 wins first.
//   - All outputs reset to 0.
// - IDLE:
//   - The winner is the first enabled port searching from last_grant+1, wrapping modulo NUM_PORTS.
//   - port_ready[winner] = 1, combinational from port_enable. Every other port_ready bit is 0.
//   - On accept: latch the request payload and the grant index; last_grant <= winner; go to ISSUE.
// - ISSUE:
//   - memory_enable = 1 with the latched payload.
//   - If memory_ready: go to WAIT. If memory_valid arrives in the same cycle, go straight to RESPOND.
// - WAIT: memory_enable = 0. On memory_valid: latch read_memory_data; go to RESPOND.
// - RESPOND:
//   - port_valid[grant] = 1 for exactly one cycle; port_read_data = latched data; go to IDLE.
// - port_ready is 0 in every state other than IDLE.
// - Losing ports must hold enable and payload stable until they see ready. A request dropped while unready is ignored.
// - memory_valid outside ISSUE/WAIT is ignored and flagged by an assertion.
// - Minimum latency, with memory_ready=1 and memory_valid one cycle after acceptance:
//   - accept at T, memory_enable at T+1, memory_valid at T+2, port_valid at T+3.
//   - The next accept is possible at T+4.
// - Fairness: a continuously enabled port is granted within NUM_PORTS transactions.
// - Asynchronous reset mid-transaction:
//   - Immediate return to IDLE with outputs cleared.
//   - The in-flight transaction is abandoned; no port_valid is issued for it.
// CONFIGURATION
// - CORE_MEMORY_ARBITER_FIXED_PRIORITY_EN defined:
//   - Fixed priority, lowest index wins.
//   - last_grant is not used for selection.
//   - No fairness guarantee.
// - CORE_MEMORY_ARBITER_FIXED_PRIORITY_EN undefined: round-robin as above.
// TESTING
// - Single read: port0 reads 0x100, memory returns 0xDEADBEEF after 1 cycle
//   -> port_valid[0] at T+3 with port_read_data=0xDEADBEEF.
// - Contention: ports 0 and 1 enabled continuously, 4 transactions
//   -> grants 0,1,0,1.
//   -> With FIXED_PRIORITY_EN: grants 0,0,0,0.
// - Backpressure: memory_ready low 5 cycles in ISSUE
//   -> memory_enable and payload held stable; no port_ready asserted.
// - Write: port1 writes 0x55AA55AA, mask 0x0000FFFF, to 0x200
//   -> downstream sees command=1 with the same values; port_valid[1] pulses once.
// - Reset in WAIT: assert reset, release, then memory_valid
//   -> no port_valid; state is IDLE; port 0 wins the next grant.
// - Same-cycle ready and valid in ISSUE -> RESPOND next cycle; WAIT is skipped.

Source files
------------

// File: rtl/core_memory_arbiter_if.sv
// Core-side request ports and downstream memory port of core_memory_arbiter.
// slave: the arbiter's view; master: the cores plus memory that surround it.
interface core_memory_arbiter_if #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [NUM_PORTS-1:0]            port_enable;
  logic [NUM_PORTS-1:0]            port_command;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_read_address;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_write_address;
  logic [NUM_PORTS*DATA_WIDTH-1:0] port_write_data;
  logic [NUM_PORTS*DATA_WIDTH-1:0] port_write_mask;
  logic [NUM_PORTS-1:0]            port_ready;
  logic [NUM_PORTS-1:0]            port_valid;
  logic [DATA_WIDTH-1:0]           port_read_data;

  logic                            memory_enable;
  logic                            memory_command;
  logic [ADDR_WIDTH-1:0]           read_memory_address;
  logic [ADDR_WIDTH-1:0]           write_memory_address;
  logic [DATA_WIDTH-1:0]           write_memory_data;
  logic [DATA_WIDTH-1:0]           write_memory_mask;
  logic                            memory_ready;
  logic                            memory_valid;
  logic [DATA_WIDTH-1:0]           read_memory_data;

  modport slave (
    input  port_enable, port_command, port_read_address, port_write_address,
           port_write_data, port_write_mask,
    output port_ready, port_valid, port_read_data,
    output memory_enable, memory_command, read_memory_address, write_memory_address,
           write_memory_data, write_memory_mask,
    input  memory_ready, memory_valid, read_memory_data
  );

  modport master (
    output port_enable, port_command, port_read_address, port_write_address,
           port_write_data, port_write_mask,
    input  port_ready, port_valid, port_read_data,
    input  memory_enable, memory_command, read_memory_address, write_memory_address,
           write_memory_data, write_memory_mask,
    output memory_ready, memory_valid, read_memory_data
  );
endinterface

// File: rtl/core_memory_arbiter.sv
// Shares one memory port among NUM_PORTS core request ports, one transaction in flight.
// Round-robin grant; define CORE_MEMORY_ARBITER_FIXED_PRIORITY_EN for lowest-index-wins.
module core_memory_arbiter #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  core_memory_arbiter_if.slave  bus
);
  localparam int unsigned GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

  state_t                state, state_next;
  logic [GW-1:0]         winner, grant;
  logic                  any_request, accept, capture;

  logic                  sel_command;
  logic [ADDR_WIDTH-1:0] sel_read_address, sel_write_address;
  logic [DATA_WIDTH-1:0] sel_write_data, sel_write_mask;

  logic                  req_command;
  logic [ADDR_WIDTH-1:0] req_read_address, req_write_address;
  logic [DATA_WIDTH-1:0] req_write_data, req_write_mask;
  logic [DATA_WIDTH-1:0] read_data;

`ifdef CORE_MEMORY_ARBITER_FIXED_PRIORITY_EN
  always_comb begin
    any_request = 1'b0;
    winner      = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (bus.port_enable[k] && !any_request) begin
        any_request = 1'b1;
        winner      = GW'(k);
      end
    end
  end
`else
  logic [GW-1:0] last_grant, winner_after;
  logic          found_after;

  // Prefer the lowest enabled index above last_grant; otherwise wrap to the lowest enabled.
  always_comb begin
    any_request  = 1'b0;
    found_after  = 1'b0;
    winner       = '0;
    winner_after = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (bus.port_enable[k]) begin
        if (!any_request) begin
          any_request = 1'b1;
          winner      = GW'(k);
        end
        if (!found_after && (GW'(k) > last_grant)) begin
          found_after  = 1'b1;
          winner_after = GW'(k);
        end
      end
    end
    if (found_after) winner = winner_after;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      last_grant <= GW'(NUM_PORTS - 1);
    else if (accept) last_grant <= winner;
  end
`endif

  always_comb begin
    sel_command       = 1'b0;
    sel_read_address  = '0;
    sel_write_address = '0;
    sel_write_data    = '0;
    sel_write_mask    = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (GW'(k) == winner) begin
        sel_command       = bus.port_command[k];
        sel_read_address  = bus.port_read_address[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_write_address = bus.port_write_address[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_write_data    = bus.port_write_data[k*DATA_WIDTH +: DATA_WIDTH];
        sel_write_mask    = bus.port_write_mask[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (any_request) begin
          accept     = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.memory_ready) begin
          if (bus.memory_valid) begin
            capture    = 1'b1;
            state_next = RESPOND;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.memory_valid) begin
          capture    = 1'b1;
          state_next = RESPOND;
        end
      end
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      grant             <= '0;
      req_command       <= 1'b0;
      req_read_address  <= '0;
      req_write_address <= '0;
      req_write_data    <= '0;
      req_write_mask    <= '0;
      read_data         <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        grant             <= winner;
        req_command       <= sel_command;
        req_read_address  <= sel_read_address;
        req_write_address <= sel_write_address;
        req_write_data    <= sel_write_data;
        req_write_mask    <= sel_write_mask;
      end
      if (capture) read_data <= bus.read_memory_data;
    end
  end

  assign bus.port_ready = (state == IDLE && any_request) ? (NUM_PORTS'(1) << winner) : '0;
  assign bus.port_valid = (state == RESPOND) ? (NUM_PORTS'(1) << grant) : '0;
  assign bus.port_read_data       = read_data;
  assign bus.memory_enable        = (state == ISSUE);
  assign bus.memory_command       = req_command;
  assign bus.read_memory_address  = req_read_address;
  assign bus.write_memory_address = req_write_address;
  assign bus.write_memory_data    = req_write_data;
  assign bus.write_memory_mask    = req_write_mask;

  // A stray completion is dropped by the FSM; flag it without stopping the run.
  always_ff @(posedge clk) begin
    if (reset && bus.memory_valid)
      assert (state == ISSUE || state == WAIT)
        else $warning("core_memory_arbiter: memory_valid ignored outside an active transaction");
  end
endmodule

// File: tb/tb_core_memory_arbiter.sv
// Randomized and directed bench for core_memory_arbiter against a transaction-level model.
module tb_core_memory_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  core_memory_arbiter_if #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  core_memory_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct packed {
    logic        cmd;
    logic [31:0] raddr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] wmask;
  } req_t;

  // Stimulus state: a port keeps its request (pend bit + payload) until it is accepted.
  req_t        port_req [N];
  logic [N-1:0] pend;
  logic        mem_ready, mem_valid;
  logic [31:0] mem_data;

  // Model: one transaction record and the round-robin pointer.
  bit          m_busy, m_taken, m_done;
  int          m_owner, m_last;
  req_t        m_req;
  logic [31:0] m_data;
  int          grant_log [$];
  int          waits [N];

  logic [N-1:0] obs_ready, obs_valid;
  logic         obs_mem_en;
  logic [31:0]  obs_rdata;
  req_t         obs_payload;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int pick_winner(input logic [N-1:0] en);
`ifdef CORE_MEMORY_ARBITER_FIXED_PRIORITY_EN
    for (int i = 0; i < N; i++)
      if (((en >> i) & N'(1)) != 0) return i;
`else
    for (int k = 1; k <= N; k++) begin
      int idx = (m_last + k) % N;
      if (((en >> idx) & N'(1)) != 0) return idx;
    end
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_taken = 0; m_done = 0;
    m_owner = 0; m_last = N - 1; m_data = '0; m_req = '0;
    grant_log.delete();
    for (int i = 0; i < N; i++) waits[i] = 0;
  endtask

  task automatic set_req(input int p, input logic cmd, input logic [31:0] raddr,
                         input logic [31:0] waddr, input logic [31:0] wdata, input logic [31:0] wmask);
    port_req[p] = '{cmd: cmd, raddr: raddr, waddr: waddr, wdata: wdata, wmask: wmask};
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      bus.port_enable[i]                 = pend[i];
      bus.port_command[i]                = port_req[i].cmd;
      bus.port_read_address[i*AW +: AW]  = port_req[i].raddr;
      bus.port_write_address[i*AW +: AW] = port_req[i].waddr;
      bus.port_write_data[i*DW +: DW]    = port_req[i].wdata;
      bus.port_write_mask[i*DW +: DW]    = port_req[i].wmask;
    end
    bus.memory_ready     = mem_ready;
    bus.memory_valid     = mem_valid;
    bus.read_memory_data = mem_data;
  endtask

  // One clock: drive, compare at negedge, advance the model at posedge.
  task automatic step();
    int w;
    logic [N-1:0] exp_ready, exp_valid;
    logic exp_mem_en;
    apply();
    @(negedge clk);
    w          = m_busy ? -1 : pick_winner(pend);
    exp_ready  = (w >= 0) ? (N'(1) << w) : '0;
    exp_valid  = (m_busy && m_done) ? (N'(1) << m_owner) : '0;
    exp_mem_en = m_busy && !m_taken;
    obs_ready   = bus.port_ready;
    obs_valid   = bus.port_valid;
    obs_mem_en  = bus.memory_enable;
    obs_rdata   = bus.port_read_data;
    obs_payload = {bus.memory_command, bus.read_memory_address, bus.write_memory_address,
                   bus.write_memory_data, bus.write_memory_mask};
    check("port_ready", obs_ready, exp_ready);
    check("port_valid", obs_valid, exp_valid);
    check("memory_enable", obs_mem_en, exp_mem_en);
    if (exp_valid != 0) check("port_read_data", obs_rdata, m_data);
    if (exp_mem_en)     check("memory_payload", obs_payload, m_req);
    @(posedge clk);
    if (!m_busy) begin
      if (w >= 0) begin
`ifndef CORE_MEMORY_ARBITER_FIXED_PRIORITY_EN
        check("fairness_wait", (waits[w] <= N - 1), 1'b1);
`endif
        waits[w] = 0;
        for (int i = 0; i < N; i++)
          if (i != w && pend[i]) waits[i]++;
        m_busy = 1; m_taken = 0; m_done = 0;
        m_owner = w; m_last = w; m_req = port_req[w];
        grant_log.push_back(w);
        pend = pend & ~(N'(1) << w);
      end
    end else if (m_done) begin
      m_busy = 0;
    end else if (!m_taken) begin
      if (mem_ready) begin
        m_taken = 1;
        if (mem_valid) begin m_done = 1; m_data = mem_data; end
      end
    end else if (mem_valid) begin
      m_done = 1; m_data = mem_data;
    end
    #1;
  endtask

  task automatic idle_inputs();
    pend = '0; mem_ready = 0; mem_valid = 0; mem_data = '0;
    for (int i = 0; i < N; i++) port_req[i] = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    apply();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {bus.port_ready, bus.port_valid, bus.memory_enable, bus.port_read_data,
                            bus.read_memory_address, bus.write_memory_mask}, '0);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Fast memory: accept at once and complete in the same cycle.
  task automatic mem_auto();
    mem_ready = 1;
    mem_valid = m_busy && !m_done;
    mem_data  = $urandom;
  endtask

  task automatic drain();
    for (int c = 0; c < 60; c++) begin
      if (!m_busy && pend == 0) break;
      mem_auto();
      step();
    end
    if (m_busy || pend != 0) begin
      total++;
      $display("FAIL drain_timeout: busy=%0d pend=%0b required idle", m_busy, pend);
    end
    mem_valid = 0;
  endtask

  task automatic rand_drive();
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && $urandom_range(0, 2) == 0) begin
        pend[i] = 1'b1;
        set_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, $urandom);
      end
    end
    mem_data = $urandom;
    if (m_busy && !m_taken) begin
      mem_ready = ($urandom_range(0, 2) != 0);
      mem_valid = mem_ready && ($urandom_range(0, 3) == 0);
    end else if (m_busy && !m_done) begin
      mem_ready = 1'($urandom_range(0, 1));
      mem_valid = ($urandom_range(0, 2) == 0);
    end else begin
      mem_ready = 1'($urandom_range(0, 1));
      mem_valid = 0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int exp_grants [4];
    int pulses;

    // Single read at 0x100
    do_reset();
    set_req(0, 1'b0, 32'h100, 32'h0, 32'h0, 32'h0);
    pend = 3'b001; mem_ready = 1;
    step();
    check("read_ready_T", obs_ready, 3'b001);
    step();
    check("read_issue_T1", {obs_mem_en, obs_payload.cmd, obs_payload.raddr}, {1'b1, 1'b0, 32'h100});
    mem_valid = 1; mem_data = 32'hDEADBEEF;
    step();
    check("read_wait_T2", {obs_mem_en, obs_valid}, '0);
    mem_valid = 0;
    step();
    check("read_valid_T3", {obs_valid, obs_rdata}, {3'b001, 32'hDEADBEEF});
    pend = 3'b001;
    step();
    check("read_next_accept_T4", obs_ready, 3'b001);
    drain();

    // Contention between ports 0 and 1
    do_reset();
    set_req(0, 1'b0, 32'h1000, 32'h0, 32'h0, 32'h0);
    set_req(1, 1'b0, 32'h2000, 32'h0, 32'h0, 32'h0);
    for (int c = 0; c < 40 && grant_log.size() < 4; c++) begin
      pend = 3'b011;
      mem_auto();
      step();
    end
`ifdef CORE_MEMORY_ARBITER_FIXED_PRIORITY_EN
    exp_grants = '{0, 0, 0, 0};
`else
    exp_grants = '{0, 1, 0, 1};
`endif
    if (grant_log.size() < 4) begin
      total++;
      $display("FAIL contention_timeout: grants=%0d required 4", grant_log.size());
    end else begin
      for (int i = 0; i < 4; i++)
        check($sformatf("contention_grant%0d", i), grant_log[i], exp_grants[i]);
    end
    pend = '0;
    drain();

    // Backpressure in ISSUE with competing requests
    do_reset();
    set_req(0, 1'b0, 32'h300, 32'h0, 32'h0, 32'h0);
    set_req(1, 1'b0, 32'h400, 32'h0, 32'h0, 32'h0);
    set_req(2, 1'b1, 32'h0, 32'h500, 32'h1, 32'hF);
    pend = 3'b001; mem_ready = 0;
    step();
    pend = 3'b111;
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("backpressure_hold%0d", c), {obs_mem_en, obs_payload.raddr, obs_ready},
            {1'b1, 32'h300, 3'b000});
    end
    mem_ready = 1;
    step();
    mem_valid = 1; mem_data = 32'hCAFEF00D;
    step();
    mem_valid = 0;
    step();
    check("backpressure_valid", {obs_valid, obs_rdata}, {3'b001, 32'hCAFEF00D});
    drain();

    // Masked write from port 1
    do_reset();
    set_req(1, 1'b1, 32'h0, 32'h200, 32'h55AA55AA, 32'h0000FFFF);
    pend = 3'b010; mem_ready = 1;
    step();
    check("write_ready", obs_ready, 3'b010);
    step();
    check("write_payload", {obs_mem_en, obs_payload},
          {1'b1, 1'b1, 32'h0, 32'h200, 32'h55AA55AA, 32'h0000FFFF});
    mem_valid = 1; mem_data = 32'h0;
    step();
    mem_valid = 0;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (obs_valid[1]) pulses++;
    end
    check("write_ack_pulses", pulses, 1);

    // Reset while waiting for memory
    do_reset();
    set_req(0, 1'b0, 32'h100, 32'h0, 32'h0, 32'h0);
    pend = 3'b001; mem_ready = 1;
    step();
    step();
    mem_ready = 0;
    apply();
    #2 reset = 1'b0;
    #1;
    check("reset_wait_cleared", {bus.memory_enable, bus.port_valid, bus.port_ready,
                                 bus.read_memory_address}, '0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    mem_valid = 1; mem_data = 32'h0BADF00D;
    step();
    check("reset_stray_valid0", obs_valid, 3'b000);
    mem_valid = 0;
    step();
    check("reset_stray_valid1", obs_valid, 3'b000);
    set_req(1, 1'b0, 32'h10, 32'h0, 32'h0, 32'h0);
    set_req(2, 1'b0, 32'h20, 32'h0, 32'h0, 32'h0);
    pend = 3'b111;
    step();
    check("reset_port0_wins", obs_ready, 3'b001);
    drain();

    // Same-cycle ready and valid skips WAIT
    do_reset();
    set_req(0, 1'b0, 32'h600, 32'h0, 32'h0, 32'h0);
    pend = 3'b001; mem_ready = 1;
    step();
    mem_valid = 1; mem_data = 32'h12345678;
    step();
    check("same_cycle_issue", obs_mem_en, 1'b1);
    mem_valid = 0;
    step();
    check("same_cycle_respond", {obs_valid, obs_rdata}, {3'b001, 32'h12345678});
    drain();

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rand_drive();
      step();
    end
    pend = '0;
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
